// File: rtl/fetch_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_if
// Brief    : Instruction-memory and decode-side bundle for the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_prefetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic                      halt_PC;
  logic                      flush;
  logic [ADDR_W-1:0]         branch_target;
  logic                      imem_req;
  logic [ADDR_W-1:0]         imem_addr;
  logic                      imem_ready;
  logic                      imem_rvalid;
  logic [INSTR_W-1:0]        imem_rdata;
  logic                      f_valid;
  logic                      f_ready;
  logic [ADDR_W+INSTR_W-1:0] F_out;
  logic [ADDR_W-1:0]         pc;

  modport master (
    input  halt_PC, flush, branch_target, imem_ready, imem_rvalid, imem_rdata, f_ready,
    output imem_req, imem_addr, f_valid, F_out, pc
  );

  modport slave (
    output halt_PC, flush, branch_target, imem_ready, imem_rvalid, imem_rdata, f_ready,
    input  imem_req, imem_addr, f_valid, F_out, pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Brief    : Credit-limited fetch stage with prefetch queue, flush and halt.
// Revision : 1.0
// ============================================================================
module fetch_prefetch #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int PC_INC   = 2,
  parameter int RESET_PC = 0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fetch_prefetch_if.master   fp
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 4;
  localparam int c_ENT_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0]  c_PC_INC   = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0]  c_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [c_ENT_W-1:0] r_q [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [c_CNT_W-1:0] r_out;
  logic [c_CNT_W-1:0] r_drop;

  logic [c_CNT_W-1:0] w_live;
  logic [c_CNT_W-1:0] w_used;
  logic               w_req;
  logic               w_issue;
  logic               w_fvalid;
  logic               w_push;
  logic               w_pop;
  logic               w_dropping;
  logic [c_ENT_W-1:0] w_entry;

  // Responses already marked for dropping do not hold a queue credit.
  assign w_live     = r_out - r_drop;
  assign w_used     = c_CNT_W'(r_count) + w_live;
  assign w_req      = rst_n & ~fp.flush & ~fp.halt_PC & (w_used < c_DEPTH);
  assign w_issue    = w_req & fp.imem_ready;
  assign w_fvalid   = rst_n & (r_count != '0);
  assign w_dropping = (r_drop != '0);
  assign w_push     = rst_n & fp.imem_rvalid & ~w_dropping & ~fp.flush;
  assign w_pop      = w_fvalid & fp.f_ready & ~fp.flush;
  assign w_entry    = {r_resp_pc + c_PC_INC, fp.imem_rdata};

  assign fp.imem_req  = w_req;
  assign fp.imem_addr = r_pc;
  assign fp.pc        = r_pc;
  assign fp.f_valid   = w_fvalid;
  assign fp.F_out     = r_q[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= c_RESET_PC;
      r_resp_pc <= c_RESET_PC;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out     <= '0;
      r_drop    <= '0;
    end else if (fp.flush) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_pc      <= fp.branch_target;
      r_resp_pc <= fp.branch_target;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out     <= r_out - c_CNT_W'(fp.imem_rvalid);
      r_drop    <= r_out - c_CNT_W'(fp.imem_rvalid);
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + c_PC_INC;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + c_PC_INC;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
      r_out   <= r_out + c_CNT_W'(w_issue) - c_CNT_W'(fp.imem_rvalid);
      if (fp.imem_rvalid && w_dropping) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wr_ptr] <= w_entry;
    end
  end
endmodule
`default_nettype wire

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised fetch stage for the pipelined core that decouples instruction memory from decode. It uses a request/response instruction-memory interface that tolerates variable latency and buffers fetched instructions in a DEPTH-entry prefetch queue. It handles branch redirect (flush), decode backpressure (stall), and halt. It drives decode with a valid/ready handshake carrying {pc_plus_inc, instruction}.

Parameters:
ADDR_W, 16, PC/address width
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
PC_INC, 2, PC increment per instruction
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock; single clock domain, all state on rising edge
rst_n  in  1  synchronous active-low reset
halt_PC  in  1  stop issuing new fetches; ignored in any cycle where flush=1
flush  in  1  redirect: discard queue and in-flight responses, restart at branch_target
branch_target  in  ADDR_W  redirect address, sampled when flush=1
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_rdata  in  INSTR_W  fetched instruction
f_valid  out  1  queue head valid toward decode
f_ready  in  1  decode accepts head; low = stall
F_out  out  ADDR_W+INSTR_W  {[ADDR_W+INSTR_W-1:INSTR_W] pc_plus_inc, [INSTR_W-1:0] instruction} of head
pc  out  ADDR_W  next address to be requested

Behaviour:
- Reset (rst_n=0 at clock edge): pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
  - imem_req=0 and f_valid=0 while rst_n=0.
  - Reset mid-operation discards everything; late responses after reset are ignored only if drop_cnt covers them. The memory is reset together with this block, so none arrive.
- Credit rule: imem_req = rst_n & !flush & !halt_PC & (count + outstanding - drop_cnt < DEPTH). The queue can never overflow.
- Issue: on imem_req & imem_ready, pc <= pc + PC_INC (modulo 2^ADDR_W wrap) and outstanding += 1.
- Response, drop_cnt>0: discard response, drop_cnt -= 1, outstanding -= 1.
- Response, drop_cnt=0: push {resp_pc + PC_INC, imem_rdata}, resp_pc += PC_INC, outstanding -= 1.
- Head: f_valid = !empty; F_out = head entry, combinational from queue storage.
- Pop: on f_valid & f_ready. Push and pop in the same cycle are both performed; count is unchanged.
- Minimum latency: request accepted in cycle N, response in N+1, f_valid in N+2.
- Flush (highest priority):
  - No request issued that cycle.
  - Queue cleared; a pop that cycle is ignored.
  - Any imem_rvalid that cycle is discarded.
  - Next-state values:
    - pc <= branch_target
    - resp_pc <= branch_target
    - drop_cnt <= outstanding - imem_rvalid
    - outstanding unchanged except the response decrement
  - Requests to branch_target start the next cycle, subject to credits.
  - A second flush while drop_cnt>0 accumulates the same way.
- Halt: with halt_PC=1 and flush=0, pc freezes and no requests are issued. In-flight responses still complete and the queue drains to decode normally.
- Stall: f_ready=0 holds the head stable. The queue fills; requests stop once credits are exhausted.
- imem_ready=0: imem_req and imem_addr stay stable until accepted or until flush/halt deasserts the request.
- Arithmetic: all PC additions are ADDR_W bits and wrap silently (0xFFFE + 2 = 0x0000 for defaults).

Test Plan:
1. Reset then stream: 1-cycle memory returning addr-derived data, f_ready=1.
   -> Requests at 0x0000, 0x0002, 0x0004, ... one per cycle.
   -> First F_out = {0x0002, mem[0]} two cycles after reset release; steady state one instruction per cycle.
2. Stall fill: f_ready=0 for 10 cycles.
   -> Exactly 4 entries captured (count + outstanding never exceeds 4); imem_req drops.
   -> On f_ready=1, entries for 0x0000–0x0006 pop in order with no loss or duplicate.
3. Flush with in-flight data: 3-cycle latency memory, 3 requests outstanding, flush with branch_target=0x0040.
   -> Those 3 responses are discarded.
   -> The first F_out after flush = {0x0042, mem[0x0040]}; no stale instruction ever reaches decode.
4. Halt vs flush: halt_PC=1 then halt_PC=1 and flush=1 to 0x0100.
   -> pc frozen during halt-only cycles; queued entries drain.
   -> Flush cycle loads pc=0x0100; issue stays blocked while halt_PC remains 1.
5. Backpressure from memory: imem_ready=0 for 5 cycles at pc=0x0010.
   -> imem_addr held at 0x0010; pc does not advance; resumes at 0x0010 on ready.
6. Wrap and sync reset: pc at 0xFFFE issues, then 0x0000; F_out pc field 0x0000.
   -> Assert rst_n=0 mid-stream: next edge f_valid=0, pc=RESET_PC, imem_req=0.
